vc_flow_controller: RTL and testbench

//  Central sequencer for the interconnect device. Latches the FIFO thresholds during init,

---
 rtl/vc_flow_if.sv | 26 ++
 rtl/vc_flow_controller.sv | 142 ++++++++++++++
 tb/tb_vc_flow_controller.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/vc_flow_if.sv
// FIFO-bank handshake between the flow controller (master) and the VC/D FIFO bank (slave).
// Flag bit order for fifo_empty/fifo_error is {D1,D0,VC1,VC0,M}.
interface vc_flow_if;
  logic [4:0] fifo_empty;
  logic [4:0] fifo_error;
  logic       vc0_head_dest;
  logic       vc1_head_dest;
  logic       d0_almost_full;
  logic       d1_almost_full;
  logic       pop_vc0;
  logic       pop_vc1;
  logic       push_d0;
  logic       push_d1;

  modport master (
    input  fifo_empty, fifo_error, vc0_head_dest, vc1_head_dest,
           d0_almost_full, d1_almost_full,
    output pop_vc0, pop_vc1, push_d0, push_d1
  );

  modport slave (
    output fifo_empty, fifo_error, vc0_head_dest, vc1_head_dest,
           d0_almost_full, d1_almost_full,
    input  pop_vc0, pop_vc1, push_d0, push_d1
  );
endinterface

// File: rtl/vc_flow_controller.sv
// Device sequencer: threshold latching, RESET/INIT/IDLE/ACTIVE/ERROR FSM and VC->D arbitration.
// Define RR_ARB_EN for round-robin between VC0/VC1; default build is VC0 strict priority.
module vc_flow_controller #(
  parameter int unsigned PTR_L        = 5,
  parameter int unsigned UMBRAL_FULL  = 3,
  parameter int unsigned UMBRAL_EMPTY = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             init,
  input  logic [PTR_L-1:0] umbral_M_full,
  input  logic [PTR_L-1:0] umbral_M_empty,
  input  logic [PTR_L-1:0] umbral_V_full,
  input  logic [PTR_L-1:0] umbral_V_empty,
  input  logic [PTR_L-1:0] umbral_D_full,
  input  logic [PTR_L-1:0] umbral_D_empty,
  output logic [PTR_L-1:0] umbral_M_full_o,
  output logic [PTR_L-1:0] umbral_M_empty_o,
  output logic [PTR_L-1:0] umbral_V_full_o,
  output logic [PTR_L-1:0] umbral_V_empty_o,
  output logic [PTR_L-1:0] umbral_D_full_o,
  output logic [PTR_L-1:0] umbral_D_empty_o,
  vc_flow_if.master        fifo_if,
  output logic             idle_out,
  output logic             active_out,
  output logic             error_out,
  output logic [4:0]       errors
);

  localparam int unsigned VC0_B = 1;
  localparam int unsigned VC1_B = 2;

  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_INIT   = 3'd1,
    S_IDLE   = 3'd2,
    S_ACTIVE = 3'd3,
    S_ERROR  = 3'd4
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   err_now;
  logic   all_empty;
  logic   pop_any;
  logic   el0;
  logic   el1;
  logic   can_pop;
  logic   gnt0;
  logic   gnt1;
  logic   gnt_dest;
  logic   pend_dest;
`ifdef RR_ARB_EN
  logic   last_grant;
`endif

  // Next state, eligibility and grant; pops only while ACTIVE persists.
  always_comb begin
    err_now   = (state != S_RESET) && (|fifo_if.fifo_error);
    all_empty = &fifo_if.fifo_empty;
    pop_any   = fifo_if.pop_vc0 | fifo_if.pop_vc1;
    el0 = !fifo_if.fifo_empty[VC0_B] &&
          !(fifo_if.vc0_head_dest ? fifo_if.d1_almost_full : fifo_if.d0_almost_full);
    el1 = !fifo_if.fifo_empty[VC1_B] &&
          !(fifo_if.vc1_head_dest ? fifo_if.d1_almost_full : fifo_if.d0_almost_full);

    state_nxt = state;
    case (state)
      S_RESET:  state_nxt = S_INIT;
      S_INIT:   if (!init) state_nxt = S_IDLE;
      S_IDLE: begin
        if (init)            state_nxt = S_INIT;
        else if (!all_empty) state_nxt = S_ACTIVE;
      end
      S_ACTIVE: begin
        if (init)                       state_nxt = S_INIT;
        else if (all_empty && !pop_any) state_nxt = S_IDLE;
      end
      S_ERROR:  state_nxt = S_ERROR;
      default:  state_nxt = S_RESET;
    endcase
    if (err_now) state_nxt = S_ERROR;

    can_pop = (state == S_ACTIVE) && (state_nxt == S_ACTIVE);
`ifdef RR_ARB_EN
    // last_grant=1 means VC1 went last, so VC0 takes a contested cycle
    gnt0 = can_pop && el0 && (!el1 || last_grant);
`else
    gnt0 = can_pop && el0;
`endif
    gnt1     = can_pop && el1 && !gnt0;
    gnt_dest = gnt0 ? fifo_if.vc0_head_dest : fifo_if.vc1_head_dest;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= S_RESET;
      fifo_if.pop_vc0  <= 1'b0;
      fifo_if.pop_vc1  <= 1'b0;
      fifo_if.push_d0  <= 1'b0;
      fifo_if.push_d1  <= 1'b0;
      pend_dest        <= 1'b0;
      idle_out         <= 1'b0;
      active_out       <= 1'b0;
      error_out        <= 1'b0;
      errors           <= 5'd0;
      umbral_M_full_o  <= PTR_L'(UMBRAL_FULL);
      umbral_M_empty_o <= PTR_L'(UMBRAL_EMPTY);
      umbral_V_full_o  <= PTR_L'(UMBRAL_FULL);
      umbral_V_empty_o <= PTR_L'(UMBRAL_EMPTY);
      umbral_D_full_o  <= PTR_L'(UMBRAL_FULL);
      umbral_D_empty_o <= PTR_L'(UMBRAL_EMPTY);
`ifdef RR_ARB_EN
      last_grant       <= 1'b1;
`endif
    end else begin
      state           <= state_nxt;
      fifo_if.pop_vc0 <= gnt0;
      fifo_if.pop_vc1 <= gnt1;
      // Popped word lands in its destination one cycle later, whatever the FSM does
      pend_dest       <= gnt_dest;
      fifo_if.push_d0 <= pop_any && !pend_dest;
      fifo_if.push_d1 <= pop_any && pend_dest;
      idle_out        <= (state_nxt == S_IDLE);
      active_out      <= (state_nxt == S_ACTIVE);
      error_out       <= (state_nxt == S_ERROR);
      if (state != S_RESET) errors <= errors | fifo_if.fifo_error;
      if ((state == S_INIT) && !err_now) begin
        umbral_M_full_o  <= umbral_M_full;
        umbral_M_empty_o <= umbral_M_empty;
        umbral_V_full_o  <= umbral_V_full;
        umbral_V_empty_o <= umbral_V_empty;
        umbral_D_full_o  <= umbral_D_full;
        umbral_D_empty_o <= umbral_D_empty;
      end
`ifdef RR_ARB_EN
      if (gnt0 || gnt1) last_grant <= gnt1;
`endif
    end
  end

endmodule

// File: tb/tb_vc_flow_controller.sv
// Self-checking bench for vc_flow_controller: directed scenarios then randomized traffic,
// all outputs compared every cycle against a behavioural model.
module tb_vc_flow_controller;

  logic       clk;
  logic       reset;
  logic       init;
  logic [4:0] u_mf, u_me, u_vf, u_ve, u_df, u_de;
  logic [4:0] o_mf, o_me, o_vf, o_ve, o_df, o_de;
  logic       idle_out, active_out, error_out;
  logic [4:0] errors;

  vc_flow_if fif ();

  vc_flow_controller dut (
    .clk              (clk),
    .reset            (reset),
    .init             (init),
    .umbral_M_full    (u_mf),
    .umbral_M_empty   (u_me),
    .umbral_V_full    (u_vf),
    .umbral_V_empty   (u_ve),
    .umbral_D_full    (u_df),
    .umbral_D_empty   (u_de),
    .umbral_M_full_o  (o_mf),
    .umbral_M_empty_o (o_me),
    .umbral_V_full_o  (o_vf),
    .umbral_V_empty_o (o_ve),
    .umbral_D_full_o  (o_df),
    .umbral_D_empty_o (o_de),
    .fifo_if          (fif),
    .idle_out         (idle_out),
    .active_out       (active_out),
    .error_out        (error_out),
    .errors           (errors)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Behavioural model of the device as seen from its ports
  typedef enum {M_RESET, M_INIT, M_IDLE, M_ACTIVE, M_ERROR} mode_t;
  mode_t      m_mode = M_RESET;
  bit         e_pop0, e_pop1, e_push0, e_push1;
  bit         e_idle, e_active, e_error;
  logic [4:0] e_errors = 5'd0;
  logic [4:0] e_thr [6];
  bit         last_vc1 = 1'b1;
  bit         inflight [$];

  task automatic model_reset();
    m_mode = M_RESET;
    e_pop0 = 0; e_pop1 = 0; e_push0 = 0; e_push1 = 0;
    e_idle = 0; e_active = 0; e_error = 0;
    e_errors = 5'd0;
    e_thr[0] = 5'd3; e_thr[1] = 5'd1; e_thr[2] = 5'd3;
    e_thr[3] = 5'd1; e_thr[4] = 5'd3; e_thr[5] = 5'd1;
    last_vc1 = 1'b1;
    inflight.delete();
  endtask

  task automatic model_step();
    mode_t nx;
    bit    busy, el0, el1, w0, w1, d;
    if (reset) begin
      model_reset();
    end else begin
      busy = e_pop0 | e_pop1;
      e_push0 = 0; e_push1 = 0;
      if (inflight.size() > 0) begin
        d = inflight.pop_front();
        if (d) e_push1 = 1; else e_push0 = 1;
      end
      nx = m_mode;
      if (m_mode == M_RESET) nx = M_INIT;
      else if (m_mode == M_ERROR || fif.fifo_error != 5'd0) nx = M_ERROR;
      else if (init) nx = M_INIT;
      else if (m_mode == M_INIT) nx = M_IDLE;
      else if (m_mode == M_IDLE && fif.fifo_empty != 5'b11111) nx = M_ACTIVE;
      else if (m_mode == M_ACTIVE && fif.fifo_empty == 5'b11111 && !busy) nx = M_IDLE;
      if (m_mode == M_INIT && nx != M_ERROR) begin
        e_thr[0] = u_mf; e_thr[1] = u_me; e_thr[2] = u_vf;
        e_thr[3] = u_ve; e_thr[4] = u_df; e_thr[5] = u_de;
      end
      if (m_mode != M_RESET) e_errors = e_errors | fif.fifo_error;
      w0 = 0; w1 = 0;
      if (m_mode == M_ACTIVE && nx == M_ACTIVE) begin
        el0 = !fif.fifo_empty[1] && !(fif.vc0_head_dest ? fif.d1_almost_full : fif.d0_almost_full);
        el1 = !fif.fifo_empty[2] && !(fif.vc1_head_dest ? fif.d1_almost_full : fif.d0_almost_full);
        if (el0 && el1) begin
`ifdef RR_ARB_EN
          if (last_vc1) w0 = 1; else w1 = 1;
`else
          w0 = 1;
`endif
        end else begin
          w0 = el0; w1 = el1;
        end
        if (w0) begin last_vc1 = 0; inflight.push_back(fif.vc0_head_dest); end
        if (w1) begin last_vc1 = 1; inflight.push_back(fif.vc1_head_dest); end
      end
      e_pop0 = w0; e_pop1 = w1;
      e_idle = (nx == M_IDLE); e_active = (nx == M_ACTIVE); e_error = (nx == M_ERROR);
      m_mode = nx;
    end
  endtask

  task automatic compare_all();
    check("pop_vc0",    32'(fif.pop_vc0), 32'(e_pop0));
    check("pop_vc1",    32'(fif.pop_vc1), 32'(e_pop1));
    check("push_d0",    32'(fif.push_d0), 32'(e_push0));
    check("push_d1",    32'(fif.push_d1), 32'(e_push1));
    check("idle_out",   32'(idle_out),    32'(e_idle));
    check("active_out", 32'(active_out),  32'(e_active));
    check("error_out",  32'(error_out),   32'(e_error));
    check("errors",     32'(errors),      32'(e_errors));
    check("thr_M_full", 32'(o_mf), 32'(e_thr[0]));
    check("thr_M_empty",32'(o_me), 32'(e_thr[1]));
    check("thr_V_full", 32'(o_vf), 32'(e_thr[2]));
    check("thr_V_empty",32'(o_ve), 32'(e_thr[3]));
    check("thr_D_full", 32'(o_df), 32'(e_thr[4]));
    check("thr_D_empty",32'(o_de), 32'(e_thr[5]));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic quiet_inputs();
    init = 0;
    fif.fifo_empty = 5'b11111; fif.fifo_error = 5'd0;
    fif.vc0_head_dest = 0; fif.vc1_head_dest = 0;
    fif.d0_almost_full = 0; fif.d1_almost_full = 0;
  endtask

  task automatic bring_up();
    quiet_inputs();
    reset = 1;
    repeat (3) tick();
    reset = 0; init = 1;
    u_mf = 5'd3; u_me = 5'd2; u_vf = 5'd15; u_ve = 5'd2; u_df = 5'd3; u_de = 5'd2;
    repeat (2) tick();
    init = 0;
    tick();
  endtask

  int pops0, pops1, pushes, rem;
  bit seen;

  initial begin
    model_reset();
    quiet_inputs();
    reset = 1;
    u_mf = 0; u_me = 0; u_vf = 0; u_ve = 0; u_df = 0; u_de = 0;
    tick();
    check("rst_thr_full",  32'(o_vf), 32'd3);
    check("rst_thr_empty", 32'(o_de), 32'd1);
    check("rst_status",    32'({idle_out, active_out, error_out, errors}), 32'd0);

    // 1: init sequence latches thresholds and lands in IDLE
    bring_up();
    check("t1_thr", 32'({o_mf, o_me, o_vf, o_ve, o_df, o_de}),
          32'({5'd3, 5'd2, 5'd15, 5'd2, 5'd3, 5'd2}));
    check("t1_idle", 32'(idle_out), 32'd1);

    // 2: four words in VC0 for D0, flag tracks words not yet popped
    pops0 = 0; pushes = 0; rem = 4;
    fif.fifo_empty = 5'b11101;
    for (int c = 0; c < 14; c++) begin
      tick();
      if (fif.pop_vc0 && rem > 0) begin pops0++; rem--; end
      if (fif.push_d0) pushes++;
      fif.fifo_empty[1] = (rem == 0);
    end
    check("t2_pops", 32'(pops0), 32'd4);
    check("t2_pushes", 32'(pushes), 32'd4);
    check("t2_idle", 32'(idle_out), 32'd1);

    // 3: both VCs eligible for six grant cycles
    fif.fifo_empty = 5'b11001; fif.vc0_head_dest = 0; fif.vc1_head_dest = 1;
    tick();
    pops0 = 0; pops1 = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      pops0 += int'(fif.pop_vc0); pops1 += int'(fif.pop_vc1);
    end
`ifdef RR_ARB_EN
    check("t3_pops_vc0", 32'(pops0), 32'd3);
    check("t3_pops_vc1", 32'(pops1), 32'd3);
`else
    check("t3_pops_vc0", 32'(pops0), 32'd6);
    check("t3_pops_vc1", 32'(pops1), 32'd0);
`endif

    // 4: D0 almost full blocks VC0, VC1 to D1 proceeds
    fif.d0_almost_full = 1;
    tick();
    pops0 = 0; pops1 = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      pops0 += int'(fif.pop_vc0); pops1 += int'(fif.pop_vc1);
    end
    check("t4_vc0_blocked", 32'(pops0), 32'd0);
    check("t4_vc1_flow", 32'(pops1), 32'd4);
    fif.d0_almost_full = 0; fif.fifo_empty = 5'b11101;
    tick();
    check("t4_vc0_resume", 32'(fif.pop_vc0), 32'd1);

    // 5: overflow flag during ACTIVE; ERROR is sticky and ignores init
    fif.fifo_error = 5'b00100;
    tick();
    check("t5_error_out", 32'(error_out), 32'd1);
    check("t5_errors", 32'(errors), 32'h04);
    fif.fifo_error = 5'd0; init = 1;
    repeat (3) tick();
    check("t5_held", 32'({error_out, fif.pop_vc0, fif.pop_vc1}), 32'b100);

    // 6: reset right after a pop drops the pending push
    bring_up();
    fif.fifo_empty = 5'b11101;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      tick();
      seen = fif.pop_vc0;
    end
    check("t6_pop_seen", 32'(seen), 32'd1);
    reset = 1;
    tick();
    check("t6_no_push", 32'({fif.push_d0, fif.push_d1, fif.pop_vc0}), 32'd0);
    check("t6_thr_rst", 32'(o_df), 32'd3);

    // Randomized traffic with occasional init, errors and resets
    bring_up();
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 99) < 2) || (error_out && $urandom_range(0, 9) == 0);
      init  = ($urandom_range(0, 99) < 4);
      fif.fifo_empty     = 5'($urandom());
      fif.fifo_error     = ($urandom_range(0, 199) == 0) ? 5'(1 << $urandom_range(0, 4)) : 5'd0;
      fif.vc0_head_dest  = 1'($urandom());
      fif.vc1_head_dest  = 1'($urandom());
      fif.d0_almost_full = ($urandom_range(0, 3) == 0);
      fif.d1_almost_full = ($urandom_range(0, 3) == 0);
      u_mf = 5'($urandom()); u_me = 5'($urandom()); u_vf = 5'($urandom());
      u_ve = 5'($urandom()); u_df = 5'($urandom()); u_de = 5'($urandom());
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
